// File: rtl/drag_pkg.sv
// Shared types and constants for the drag-racing race sequencer.
package drag_pkg;

  localparam int unsigned TIME_W  = 22;
  localparam int unsigned SEC_W   = 12;
  localparam int unsigned MS_W    = 10;
  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned SEC_MAX = 4095;

  localparam logic [31:0] FINISH_LINE_POS_DEFAULT = 32'd15000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISHED  = 2'd3
  } race_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Convert a millisecond count to the saturating {sec, ms} time format.
  function automatic logic [TIME_W-1:0] ms_to_time(input int unsigned total_ms);
    int unsigned sec;
    int unsigned ms;
    sec = total_ms / 32'd1000;
    ms  = total_ms % 32'd1000;
    if (sec > SEC_MAX) begin
      sec = SEC_MAX;
      ms  = MS_MAX;
    end
    return {SEC_W'(sec), MS_W'(ms)};
  endfunction

  // ms < 1000 < 2**MS_W, so the packed {sec, ms} word orders like the time itself.
  function automatic logic [1:0] win_decode(input logic [TIME_W-1:0] t1,
                                            input logic [TIME_W-1:0] t2);
    if (t1 < t2)      return WIN_P1;
    else if (t2 < t1) return WIN_P2;
    else              return WIN_TIE;
  endfunction

endpackage

// File: rtl/race_stopwatch.sv
// Saturating {sec, ms} stopwatch: synchronous clear-with-preload, advances on tick while run.
module race_stopwatch
  import drag_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [TIME_W-1:0] preload,
  input  logic              run,
  input  logic              tick,
  output logic [TIME_W-1:0] elapsed
);

  logic [SEC_W-1:0] sec_q;
  logic [MS_W-1:0]  ms_q;

  assign sec_q = elapsed[TIME_W-1:MS_W];
  assign ms_q  = elapsed[MS_W-1:0];

  // Stopwatch register: clear loads preload, otherwise count ms with sec carry and saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elapsed <= '0;
    end else if (clear) begin
      elapsed <= preload;
    end else if (run && tick) begin
      if (ms_q == MS_W'(MS_MAX)) begin
        if (sec_q != SEC_W'(SEC_MAX)) begin
          elapsed <= {sec_q + SEC_W'(1), MS_W'(0)};
        end
      end else begin
        elapsed[MS_W-1:0] <= ms_q + MS_W'(1);
      end
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: light countdown, per-player stopwatches, registered game status.
// Optional false-start penalty enabled by defining FALSE_START_EN.
module race_controller
  import drag_pkg::*;
#(
  parameter logic [31:0] FINISH_LINE_POS = FINISH_LINE_POS_DEFAULT,
  parameter int unsigned LIGHT_SECONDS   = 5,
  parameter int unsigned TICKS_PER_MS    = 65000,
  parameter int unsigned PENALTY_MS      = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_game,
  input  logic              back_to_menu,
  input  logic [31:0]       p1_position,
  input  logic [31:0]       p2_position,
  input  logic              p1_throttle,
  input  logic              p2_throttle,
  output logic [1:0]        state,
  output logic [2:0]        light_seconds,
  output logic              p1_enable,
  output logic              p2_enable,
  output logic              p1_finished,
  output logic              p2_finished,
  output logic [TIME_W-1:0] p1_time,
  output logic [TIME_W-1:0] p2_time,
  output logic [1:0]        winner,
  output logic              end_game,
  output logic              p1_false_start,
  output logic              p2_false_start
);

  localparam int unsigned PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TIME_W-1:0] PENALTY_TIME = ms_to_time(PENALTY_MS);
  localparam logic [TIME_W-1:0] LIGHT_LAST_MS = {SEC_W'(LIGHT_SECONDS - 1), MS_W'(MS_MAX)};

  race_state_t        cur_state;
  logic [PRESC_W-1:0] presc;
  logic               ms_tick;
  logic [TIME_W-1:0]  cd_time;
  logic               countdown_entry;
  logic               race_entry;
  logic               p1_cross;
  logic               p2_cross;
  logic               p1_fs_next;
  logic               p2_fs_next;
  logic [TIME_W-1:0]  p1_preload;
  logic [TIME_W-1:0]  p2_preload;

  assign state         = cur_state;
  assign light_seconds = cd_time[MS_W +: 3];

  assign ms_tick = ((cur_state == ST_COUNTDOWN) || (cur_state == ST_RACE)) &&
                   (presc == PRESC_W'(TICKS_PER_MS - 1));

  assign countdown_entry = (cur_state == ST_IDLE) && start_game && !back_to_menu;
  // Leave the countdown on the same edge the last millisecond of the final second rolls over.
  assign race_entry = (cur_state == ST_COUNTDOWN) && ms_tick && (cd_time == LIGHT_LAST_MS) &&
                      !back_to_menu;

  assign p1_cross = (p1_position >= FINISH_LINE_POS);
  assign p2_cross = (p2_position >= FINISH_LINE_POS);

`ifdef FALSE_START_EN
  assign p1_fs_next = p1_false_start | ((cur_state == ST_COUNTDOWN) & p1_throttle);
  assign p2_fs_next = p2_false_start | ((cur_state == ST_COUNTDOWN) & p2_throttle);
`else
  logic unused_throttle;
  assign unused_throttle = p1_throttle ^ p2_throttle;
  assign p1_fs_next = 1'b0;
  assign p2_fs_next = 1'b0;
`endif

  assign p1_preload = (p1_fs_next && !back_to_menu) ? PENALTY_TIME : '0;
  assign p2_preload = (p2_fs_next && !back_to_menu) ? PENALTY_TIME : '0;

  // Millisecond prescaler, restarted on every phase entry so the first tick lands TICKS_PER_MS clk later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (back_to_menu || countdown_entry || race_entry) begin
      presc <= '0;
    end else if ((cur_state == ST_COUNTDOWN) || (cur_state == ST_RACE)) begin
      presc <= ms_tick ? '0 : presc + PRESC_W'(1);
    end else begin
      presc <= '0;
    end
  end

  race_stopwatch u_countdown (
    .clk     (clk),
    .reset   (reset),
    .clear   (back_to_menu || countdown_entry),
    .preload ('0),
    .run     (cur_state == ST_COUNTDOWN),
    .tick    (ms_tick),
    .elapsed (cd_time)
  );

  // A player's watch stops on the crossing edge itself, so the frozen time is the one shown then.
  race_stopwatch u_p1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (back_to_menu || race_entry),
    .preload (p1_preload),
    .run     ((cur_state == ST_RACE) && !p1_finished && !p1_cross),
    .tick    (ms_tick),
    .elapsed (p1_time)
  );

  race_stopwatch u_p2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (back_to_menu || race_entry),
    .preload (p2_preload),
    .run     ((cur_state == ST_RACE) && !p2_finished && !p2_cross),
    .tick    (ms_tick),
    .elapsed (p2_time)
  );

  // Game FSM with registered status; back_to_menu outranks every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state      <= ST_IDLE;
      p1_enable      <= 1'b0;
      p2_enable      <= 1'b0;
      p1_finished    <= 1'b0;
      p2_finished    <= 1'b0;
      winner         <= WIN_NONE;
      end_game       <= 1'b0;
      p1_false_start <= 1'b0;
      p2_false_start <= 1'b0;
    end else if (back_to_menu) begin
      cur_state      <= ST_IDLE;
      p1_enable      <= 1'b0;
      p2_enable      <= 1'b0;
      p1_finished    <= 1'b0;
      p2_finished    <= 1'b0;
      winner         <= WIN_NONE;
      end_game       <= 1'b0;
      p1_false_start <= 1'b0;
      p2_false_start <= 1'b0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start_game) cur_state <= ST_COUNTDOWN;
        end
        ST_COUNTDOWN: begin
          p1_false_start <= p1_fs_next;
          p2_false_start <= p2_fs_next;
          if (race_entry) begin
            cur_state <= ST_RACE;
            p1_enable <= 1'b1;
            p2_enable <= 1'b1;
          end
        end
        ST_RACE: begin
          if (p1_cross && !p1_finished) begin
            p1_finished <= 1'b1;
            p1_enable   <= 1'b0;
          end
          if (p2_cross && !p2_finished) begin
            p2_finished <= 1'b1;
            p2_enable   <= 1'b0;
          end
          if ((p1_finished || p1_cross) && (p2_finished || p2_cross)) begin
            cur_state <= ST_FINISHED;
            end_game  <= 1'b1;
            winner    <= win_decode(p1_time, p2_time);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
